// File: rtl/wb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_cdb_arbiter
//
// Purpose:
//   Shares the single writeback / CDB port among the functional units
//   (ALU=0, BR=1, LSU=2). Each FU offers a completed result with valid/ready.
//   At most one FU is granted per cycle. The granted result goes into a 1-entry
//   registered output slot that drives the PRF write, the CDB broadcast and ROB
//   completion.
//   Grants are round-robin. A requester that has waited STARVE_LIMIT cycles is
//   force-granted ahead of the round-robin choice. A branch-mispredict flush
//   empties the slot and blocks grants for that cycle.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   flush_i               recovery flush: drop the held result, no grant
//   fu_valid_i/fu_ready_o per-FU handshake (fu_ready_o is one-hot or zero)
//   fu_tag_i/preg/data/mispred_i
//                         per-FU result fields, FU i at [i*W +: W]
//   wb_valid_o/wb_ready_i output slot handshake
//   wb_tag/preg/data/src_fu/mispred_o
//                         fields of the held result
// -----------------------------------------------------------------------------
module wb_cdb_arbiter #(
   parameter int NUM_FU       = 3,
   parameter int DATA_W       = 32,
   parameter int TAG_W        = 4,
   parameter int PREG_W       = 6,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic [NUM_FU-1:0]          fu_valid_i,
   output logic [NUM_FU-1:0]          fu_ready_o,
   input  logic [NUM_FU*TAG_W-1:0]    fu_tag_i,
   input  logic [NUM_FU*PREG_W-1:0]   fu_preg_i,
   input  logic [NUM_FU*DATA_W-1:0]   fu_data_i,
   input  logic [NUM_FU-1:0]          fu_mispred_i,
   output logic                       wb_valid_o,
   input  logic                       wb_ready_i,
   output logic [TAG_W-1:0]           wb_tag_o,
   output logic [PREG_W-1:0]          wb_preg_o,
   output logic [DATA_W-1:0]          wb_data_o,
   output logic [$clog2(NUM_FU)-1:0]  wb_src_fu_o,
   output logic                       wb_mispred_o
);

   localparam int SRC_W = $clog2(NUM_FU);
   localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT);

   logic                slot_free;
   logic [NUM_FU-1:0]   grant;
   logic                grant_any;
   logic [SRC_W-1:0]    grant_idx;
   int                  rr_dist;

   logic                wb_valid_q, wb_valid_d;
   logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
   logic [PREG_W-1:0]   wb_preg_q, wb_preg_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic [SRC_W-1:0]    wb_src_fu_q, wb_src_fu_d;
   logic                wb_mispred_q, wb_mispred_d;
   logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [3:0]          age_q [NUM_FU];
   logic [3:0]          age_d [NUM_FU];

   // The slot can take a new result when it is empty or is being drained this cycle.
   assign slot_free = !wb_valid_q || wb_ready_i;

   // Starved requesters (lowest index first) beat round-robin. The round-robin
   // scan walks distances 0..NUM_FU-1 from rr_ptr. This keeps every vector
   // index a loop constant.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      rr_dist   = 0;
      if (!reset && !flush_i && slot_free) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (!grant_any && fu_valid_i[i] && age_q[i] == AGE_LIMIT) begin
               grant_any = 1'b1;
               grant_idx = SRC_W'(i);
            end
         end
         for (int d = 0; d < NUM_FU; d++) begin
            for (int i = 0; i < NUM_FU; i++) begin
               rr_dist = i - int'(rr_ptr_q);
               if (rr_dist < 0) begin
                  rr_dist = rr_dist + NUM_FU;
               end
               if (!grant_any && fu_valid_i[i] && rr_dist == d) begin
                  grant_any = 1'b1;
                  grant_idx = SRC_W'(i);
               end
            end
         end
      end
      grant = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         grant[i] = grant_any && (grant_idx == SRC_W'(i));
      end
   end

   assign fu_ready_o = grant;

   // Slot update priority: flush, then a new grant, then a drain with no refill.
   always_comb begin
      wb_valid_d   = wb_valid_q;
      wb_tag_d     = wb_tag_q;
      wb_preg_d    = wb_preg_q;
      wb_data_d    = wb_data_q;
      wb_src_fu_d  = wb_src_fu_q;
      wb_mispred_d = wb_mispred_q;
      rr_ptr_d     = rr_ptr_q;
      if (flush_i) begin
         wb_valid_d = 1'b0;
      end else if (grant_any) begin
         wb_valid_d  = 1'b1;
         wb_src_fu_d = grant_idx;
         for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
               wb_tag_d     = fu_tag_i[i*TAG_W +: TAG_W];
               wb_preg_d    = fu_preg_i[i*PREG_W +: PREG_W];
               wb_data_d    = fu_data_i[i*DATA_W +: DATA_W];
               wb_mispred_d = fu_mispred_i[i];
            end
         end
         rr_ptr_d = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + SRC_W'(1);
      end else if (wb_ready_i && wb_valid_q) begin
         wb_valid_d = 1'b0;
      end
      // An age counts only the cycles a still-valid requester is refused.
      for (int i = 0; i < NUM_FU; i++) begin
         if (flush_i || grant[i] || !fu_valid_i[i]) begin
            age_d[i] = '0;
         end else if (age_q[i] < AGE_LIMIT) begin
            age_d[i] = age_q[i] + 4'd1;
         end else begin
            age_d[i] = age_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid_q   <= 1'b0;
         wb_tag_q     <= '0;
         wb_preg_q    <= '0;
         wb_data_q    <= '0;
         wb_src_fu_q  <= '0;
         wb_mispred_q <= 1'b0;
         rr_ptr_q     <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         wb_valid_q   <= wb_valid_d;
         wb_tag_q     <= wb_tag_d;
         wb_preg_q    <= wb_preg_d;
         wb_data_q    <= wb_data_d;
         wb_src_fu_q  <= wb_src_fu_d;
         wb_mispred_q <= wb_mispred_d;
         rr_ptr_q     <= rr_ptr_d;
         for (int i = 0; i < NUM_FU; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

   assign wb_valid_o   = wb_valid_q;
   assign wb_tag_o     = wb_tag_q;
   assign wb_preg_o    = wb_preg_q;
   assign wb_data_o    = wb_data_q;
   assign wb_src_fu_o  = wb_src_fu_q;
   assign wb_mispred_o = wb_mispred_q;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_cdb_arbiter
//
// Purpose:
//   Self-checking bench for wb_cdb_arbiter, built with STARVE_LIMIT=2.
//   Each FU is a queue of pending results. A reference model of the grant
//   policy predicts fu_ready_o every cycle. It pushes each granted result to a
//   scoreboard, and the bench checks the held slot against the scoreboard
//   until the result drains.
// -----------------------------------------------------------------------------
module tb_wb_cdb_arbiter;

   localparam int NUM_FU       = 3;
   localparam int DATA_W       = 32;
   localparam int TAG_W        = 4;
   localparam int PREG_W       = 6;
   localparam int STARVE_LIMIT = 2;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [PREG_W-1:0] preg;
      logic [DATA_W-1:0] data;
      logic              mispred;
   } item_t;

   typedef struct packed {
      item_t      item;
      logic [1:0] src;
   } wb_t;

   logic                     clk;
   logic                     reset;
   logic                     flush_i;
   logic [NUM_FU-1:0]        fu_valid_i;
   logic [NUM_FU-1:0]        fu_ready_o;
   logic [NUM_FU*TAG_W-1:0]  fu_tag_i;
   logic [NUM_FU*PREG_W-1:0] fu_preg_i;
   logic [NUM_FU*DATA_W-1:0] fu_data_i;
   logic [NUM_FU-1:0]        fu_mispred_i;
   logic                     wb_valid_o;
   logic                     wb_ready_i;
   logic [TAG_W-1:0]         wb_tag_o;
   logic [PREG_W-1:0]        wb_preg_o;
   logic [DATA_W-1:0]        wb_data_o;
   logic [1:0]               wb_src_fu_o;
   logic                     wb_mispred_o;

   wb_cdb_arbiter #(
      .NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W),
      .PREG_W(PREG_W), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .fu_valid_i(fu_valid_i), .fu_ready_o(fu_ready_o),
      .fu_tag_i(fu_tag_i), .fu_preg_i(fu_preg_i), .fu_data_i(fu_data_i),
      .fu_mispred_i(fu_mispred_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_tag_o(wb_tag_o), .wb_preg_o(wb_preg_o), .wb_data_o(wb_data_o),
      .wb_src_fu_o(wb_src_fu_o), .wb_mispred_o(wb_mispred_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   item_t             src_q [NUM_FU][$];
   wb_t               sb_q[$];
   int                grant_log[$];
   int                out_log[$];
   logic [NUM_FU-1:0] fu_en;

   int m_rr;
   int m_age [NUM_FU];
   bit m_valid;
   bit m_known;
   int n_compared;
   int n_mismatched;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic item_t mk(input int tag, input int preg, input logic [31:0] data, input bit mis);
      item_t it;
      it.tag     = TAG_W'(tag);
      it.preg    = PREG_W'(preg);
      it.data    = data;
      it.mispred = mis;
      return it;
   endfunction

   // Each enabled FU with work presents the front of its queue until it is taken.
   task automatic applyStimulus();
      for (int i = 0; i < NUM_FU; i++) begin
         if (fu_en[i] && src_q[i].size() > 0) begin
            fu_valid_i[i]                    = 1'b1;
            fu_tag_i[i*TAG_W +: TAG_W]       = src_q[i][0].tag;
            fu_preg_i[i*PREG_W +: PREG_W]    = src_q[i][0].preg;
            fu_data_i[i*DATA_W +: DATA_W]    = src_q[i][0].data;
            fu_mispred_i[i]                  = src_q[i][0].mispred;
         end else begin
            fu_valid_i[i]                    = 1'b0;
            fu_tag_i[i*TAG_W +: TAG_W]       = '0;
            fu_preg_i[i*PREG_W +: PREG_W]    = '0;
            fu_data_i[i*DATA_W +: DATA_W]    = '0;
            fu_mispred_i[i]                  = 1'b0;
         end
      end
   endtask

   // Runs at the falling edge: predicts this cycle's grant, checks the DUT, then
   // advances the model to the state expected after the next rising edge.
   task automatic checkCycle();
      int g;
      logic [NUM_FU-1:0] v;
      wb_t rec;
      g = -1;
      v = fu_valid_i;
      if (!reset && !flush_i && (!m_valid || wb_ready_i)) begin
         for (int i = 0; i < NUM_FU; i++)
            if (g < 0 && v[i] && m_age[i] == STARVE_LIMIT) g = i;
         for (int k = 0; k < NUM_FU; k++) begin
            int j;
            j = (m_rr + k) % NUM_FU;
            if (g < 0 && v[j]) g = j;
         end
      end
      checkOutput("fu_ready", 64'(fu_ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
      if (m_known) begin
         checkOutput("wb_valid", 64'(wb_valid_o), 64'(m_valid));
         if (m_valid && sb_q.size() > 0) begin
            checkOutput("wb_tag",     64'(wb_tag_o),     64'(sb_q[0].item.tag));
            checkOutput("wb_preg",    64'(wb_preg_o),    64'(sb_q[0].item.preg));
            checkOutput("wb_data",    64'(wb_data_o),    64'(sb_q[0].item.data));
            checkOutput("wb_src_fu",  64'(wb_src_fu_o),  64'(sb_q[0].src));
            checkOutput("wb_mispred", 64'(wb_mispred_o), 64'(sb_q[0].item.mispred));
         end
      end
      if (reset) begin
         m_valid = 1'b0;
         m_rr    = 0;
         for (int i = 0; i < NUM_FU; i++) m_age[i] = 0;
         sb_q.delete();
         m_known = 1'b1;
      end else begin
         if (m_valid && (flush_i || wb_ready_i) && sb_q.size() > 0) begin
            if (!flush_i) out_log.push_back(int'(sb_q[0].item.tag));
            void'(sb_q.pop_front());
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (flush_i || !v[i] || i == g) m_age[i] = 0;
            else if (m_age[i] < STARVE_LIMIT) m_age[i]++;
         end
         if (flush_i) begin
            m_valid = 1'b0;
         end else if (g >= 0) begin
            rec.item = src_q[g][0];
            rec.src  = 2'(g);
            sb_q.push_back(rec);
            m_valid = 1'b1;
            m_rr    = (g + 1) % NUM_FU;
            grant_log.push_back(g);
            void'(src_q[g].pop_front());
         end else if (wb_ready_i) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic runCycle();
      applyStimulus();
      @(negedge clk);
      checkCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset      = 1'b1;
      flush_i    = 1'b0;
      wb_ready_i = 1'b1;
      fu_en      = '0;
      for (int i = 0; i < NUM_FU; i++) src_q[i].delete();
      runCycle();
      reset = 1'b0;
      grant_log.delete();
      out_log.delete();
   endtask

   task automatic checkGrant(input string tag, input int pos, input int exp);
      if (pos < grant_log.size()) checkOutput(tag, 64'(grant_log[pos]), 64'(exp));
      else checkOutput(tag, 64'hFFFF_FFFF, 64'(exp));
   endtask

   int exp_rr [6] = '{0, 1, 2, 0, 1, 2};

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      m_known      = 1'b0;
      m_valid      = 1'b0;
      m_rr         = 0;
      reset        = 1'b1;
      flush_i      = 1'b0;
      wb_ready_i   = 1'b1;
      fu_en        = '0;
      applyStimulus();
      @(posedge clk);
      #1;
      doReset();
      checkOutput("rst_valid",   64'(wb_valid_o),   64'd0);
      checkOutput("rst_tag",     64'(wb_tag_o),     64'd0);
      checkOutput("rst_preg",    64'(wb_preg_o),    64'd0);
      checkOutput("rst_data",    64'(wb_data_o),    64'd0);
      checkOutput("rst_src",     64'(wb_src_fu_o),  64'd0);
      checkOutput("rst_mispred", 64'(wb_mispred_o), 64'd0);

      // ALU alone streams tags 0..7 at one result per cycle.
      for (int t = 0; t < 8; t++) src_q[0].push_back(mk(t, t + 1, 32'h1000 + 32'(t), 1'b0));
      fu_en = 3'b001;
      repeat (9) runCycle();
      checkOutput("t1_count", 64'(out_log.size()), 64'd8);
      for (int i = 0; i < 8 && i < out_log.size(); i++)
         checkOutput("t1_tag_order", 64'(out_log[i]), 64'(i));

      // All three FUs busy: plain round-robin order.
      doReset();
      for (int f = 0; f < NUM_FU; f++)
         for (int n = 0; n < 4; n++)
            src_q[f].push_back(mk(f * 4 + n, 10 + f, 32'hA000_0000 + 32'(f * 16 + n), 1'b0));
      fu_en = 3'b111;
      repeat (6) runCycle();
      for (int i = 0; i < 6; i++) checkGrant("t2_rr_order", i, exp_rr[i]);
      fu_en = 3'b000;
      repeat (2) runCycle();

      // Backpressure: the held slot stays put; on release the ALU (aged) refills it.
      doReset();
      src_q[0].push_back(mk(3, 5, 32'hDEADBEEF, 1'b0));
      src_q[0].push_back(mk(4, 6, 32'h1234_5678, 1'b0));
      src_q[1].push_back(mk(9, 7, 32'h0000_00B0, 1'b0));
      wb_ready_i = 1'b0;
      fu_en      = 3'b001;
      runCycle();
      fu_en = 3'b011;
      repeat (5) runCycle();
      checkOutput("t3_hold_valid", 64'(wb_valid_o), 64'd1);
      checkOutput("t3_hold_tag",   64'(wb_tag_o),   64'd3);
      checkOutput("t3_hold_data",  64'(wb_data_o),  64'hDEADBEEF);
      wb_ready_i = 1'b1;
      runCycle();
      checkGrant("t3_refill", 1, 0);
      fu_en = 3'b000;
      repeat (2) runCycle();

      // Starvation override: the LSU reaches age 2 and wins over the RR choice (BR).
      doReset();
      src_q[0].push_back(mk(1, 1, 32'h11, 1'b0));
      src_q[0].push_back(mk(2, 2, 32'h22, 1'b0));
      src_q[1].push_back(mk(5, 3, 32'h55, 1'b0));
      src_q[2].push_back(mk(12, 4, 32'hCC, 1'b0));
      wb_ready_i = 1'b0;
      fu_en = 3'b001; runCycle();
      fu_en = 3'b110; runCycle();
      fu_en = 3'b101; runCycle();
      wb_ready_i = 1'b1;
      fu_en = 3'b111; runCycle();
      checkGrant("t4_starve", 1, 2);
      fu_en = 3'b000;
      repeat (2) runCycle();

      // Flush while a mispredicted branch is held: slot empties and rr_ptr stays at 2.
      doReset();
      src_q[1].push_back(mk(5, 0, 32'h0000_00BB, 1'b1));
      src_q[0].push_back(mk(6, 8, 32'h0000_00AA, 1'b0));
      src_q[2].push_back(mk(7, 9, 32'h0000_00CC, 1'b0));
      wb_ready_i = 1'b0;
      fu_en = 3'b010; runCycle();
      flush_i    = 1'b1;
      wb_ready_i = 1'b1;
      fu_en      = 3'b001;
      runCycle();
      checkOutput("t5_flush_valid", 64'(wb_valid_o), 64'd0);
      flush_i = 1'b0;
      fu_en   = 3'b101;
      grant_log.delete();
      runCycle();
      checkGrant("t5_rr_kept", 0, 2);
      fu_en = 3'b000;
      repeat (3) runCycle();

      // Reset mid-stream: slot empties and the first grant afterwards goes to the ALU.
      doReset();
      for (int f = 0; f < NUM_FU; f++)
         for (int n = 0; n < 3; n++)
            src_q[f].push_back(mk(f * 3 + n, 20 + n, 32'hF000_0000 + 32'(f * 8 + n), 1'b0));
      fu_en = 3'b111;
      repeat (2) runCycle();
      reset = 1'b1;
      runCycle();
      reset = 1'b0;
      checkOutput("t6_rst_valid", 64'(wb_valid_o), 64'd0);
      grant_log.delete();
      runCycle();
      checkGrant("t6_first_grant", 0, 0);
      fu_en = 3'b000;
      repeat (2) runCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
